// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: bus widths,
// FSM state encoding and mem_len decoding.
package mem_ctrl_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        IF_RD  = 2'b01,
        MEM_RD = 2'b10,
        MEM_WR = 2'b11
    } state_e;

    localparam logic [1:0] LEN_B    = 2'b00;
    localparam logic [1:0] LEN_H    = 2'b01;
    localparam logic [1:0] LEN_RSVD = 2'b10;
    localparam logic [1:0] LEN_W    = 2'b11;

    // The reserved length code behaves as a full word.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_B:   len_bytes = 3'd1;
            LEN_H:   len_bytes = 3'd2;
            default: len_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates instruction fetch and data requests onto a byte-wide RAM,
// assembling/splitting 1/2/4-byte little-endian transfers one byte per cycle.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [XLEN-1:0]   if_addr,
    output logic              if_done,
    output logic [XLEN-1:0]   if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [XLEN-1:0]   mem_addr,
    input  logic [XLEN-1:0]   mem_wdata,
    output logic              mem_done,
    output logic [XLEN-1:0]   mem_rdata,
    input  logic [BYTE_W-1:0] ram_din,
    output logic [BYTE_W-1:0] ram_dout,
    output logic [XLEN-1:0]   ram_a,
    output logic              ram_wr
);

    state_e            state_q, state_d;
    logic [XLEN-1:0]   base_q, base_d;
    logic [2:0]        nbytes_q, nbytes_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              rd_inflight_q, rd_inflight_d;
    logic [XLEN-1:0]   rbuf_q, rbuf_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;
    logic [XLEN-1:0]   if_data_q, if_data_d;
    logic [XLEN-1:0]   mem_rdata_q, mem_rdata_d;

    logic [2:0]        rd_pend;
    logic              rd_present;

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        nbytes_d      = nbytes_q;
        wdata_d       = wdata_q;
        cnt_d         = cnt_q;
        rbuf_d        = rbuf_q;
        if_done_d     = if_done_q;
        mem_done_d    = mem_done_q;
        if_data_d     = if_data_q;
        mem_rdata_d   = mem_rdata_q;
        rd_inflight_d = 1'b0;
        rd_pend       = cnt_q + {2'b00, rd_inflight_q};
        rd_present    = 1'b0;
        ram_a         = '0;
        ram_dout      = '0;
        ram_wr        = 1'b0;

        // rd_pend is the next byte not yet addressed; once it reaches the
        // length the bus goes quiet while the last byte drains.
        case (state_q)
            IF_RD, MEM_RD: begin
                rd_present = (rd_pend < nbytes_q);
                if (rd_present) begin
                    ram_a = base_q + {{(XLEN-3){1'b0}}, rd_pend};
                end
                rd_inflight_d = rdy & rd_present;
            end
            MEM_WR: begin
                ram_a  = base_q + {{(XLEN-3){1'b0}}, cnt_q};
                ram_wr = rdy;
                case (cnt_q[1:0])
                    2'd0:    ram_dout = wdata_q[7:0];
                    2'd1:    ram_dout = wdata_q[15:8];
                    2'd2:    ram_dout = wdata_q[23:16];
                    default: ram_dout = wdata_q[31:24];
                endcase
            end
            default: ;
        endcase

        if (rdy) begin
            if_done_d  = 1'b0;
            mem_done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_req && !mem_done_q) begin
                        state_d  = mem_we ? MEM_WR : MEM_RD;
                        base_d   = mem_addr;
                        nbytes_d = len_bytes(mem_len);
                        wdata_d  = mem_wdata;
                        cnt_d    = '0;
                        rbuf_d   = '0;
                    end else if (if_req && !if_done_q) begin
                        state_d  = IF_RD;
                        base_d   = if_addr;
                        nbytes_d = 3'd4;
                        cnt_d    = '0;
                        rbuf_d   = '0;
                    end
                end
                IF_RD, MEM_RD: begin
                    if (rd_inflight_q) begin
                        rbuf_d[{cnt_q[1:0], 3'b000} +: BYTE_W] = ram_din;
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_d == nbytes_q) begin
                            state_d = IDLE;
                            if (state_q == IF_RD) begin
                                if_done_d = 1'b1;
                                if_data_d = rbuf_d;
                            end else begin
                                mem_done_d  = 1'b1;
                                mem_rdata_d = rbuf_d;
                            end
                        end
                    end
                end
                MEM_WR: begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_d == nbytes_q) begin
                        state_d    = IDLE;
                        mem_done_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            base_q        <= '0;
            nbytes_q      <= '0;
            wdata_q       <= '0;
            cnt_q         <= '0;
            rd_inflight_q <= 1'b0;
            rbuf_q        <= '0;
            if_done_q     <= 1'b0;
            mem_done_q    <= 1'b0;
            if_data_q     <= '0;
            mem_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            nbytes_q      <= nbytes_d;
            wdata_q       <= wdata_d;
            cnt_q         <= cnt_d;
            rd_inflight_q <= rd_inflight_d;
            rbuf_q        <= rbuf_d;
            if_done_q     <= if_done_d;
            mem_done_q    <= mem_done_d;
            if_data_q     <= if_data_d;
            mem_rdata_q   <= mem_rdata_d;
        end
    end

    assign if_done   = if_done_q;
    assign mem_done  = mem_done_q;
    assign if_data   = if_data_q;
    assign mem_rdata = mem_rdata_q;

endmodule
